// File: rtl/dp_acc_pkg.sv
// Shared definitions for the dot-product accumulator.
//
// Holds the controller state encoding, the default widths for the
// accumulator block, and the product width that the pipelined 32x32
// Wallace multiplier also uses, so both ends of the product stream agree.
package dp_acc_pkg;

  // Product width produced by the 32x32 multiplier (unsigned 64-bit).
  localparam int unsigned MUL_PROD_W = 64;

  // Default widths for dot_product_accumulator.
  localparam int unsigned DP_PROD_W_DEF = MUL_PROD_W;
  localparam int unsigned DP_ACC_W_DEF  = 72;  // 8 guard bits over the product
  localparam int unsigned DP_LEN_W_DEF  = 8;   // up to 255 terms

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } dp_state_e;

endpackage : dp_acc_pkg

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
//
// Sums a programmed number of consecutive unsigned products from the
// multiplier and presents the total on a held valid/ready output. Together
// with the multiplier it forms a MAC / dot-product unit.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_n_i        synchronous active-low reset
//   start_i        begin a new dot product (taken in IDLE, or in HOLD when
//                  the result is consumed on the same edge)
//   len_i          number of products to sum, latched on an accepted start
//   prod_valid_i   product on prod_i is valid
//   prod_i         unsigned product from the multiplier
//   prod_ready_o   block accepts a product this cycle (ACCUM only)
//   acc_out_o      final sum, stable while acc_valid_o is high
//   acc_valid_o    result available (HOLD)
//   acc_ready_i    consumer takes the result
//   busy_o         high in ACCUM or HOLD
//   overflow_o     sticky carry out of the accumulator for this dot product
//   term_cnt_o     products accepted so far in this dot product
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; no product accepted, no result shown
//   ACCUM | accepting products until len have been summed
//   HOLD  | result on acc_out_o held until acc_ready_i
module dot_product_accumulator
  import dp_acc_pkg::*;
#(
  parameter int unsigned PROD_W = DP_PROD_W_DEF,
  parameter int unsigned ACC_W  = DP_ACC_W_DEF,
  parameter int unsigned LEN_W  = DP_LEN_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              prod_valid_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic              prod_ready_o,
  output logic [ACC_W-1:0]  acc_out_o,
  output logic              acc_valid_o,
  input  logic              acc_ready_i,
  output logic              busy_o,
  output logic              overflow_o,
  output logic [LEN_W-1:0]  term_cnt_o
);

  dp_state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q,      acc_d;
  logic [ACC_W-1:0] acc_out_q,  acc_out_d;
  logic [LEN_W-1:0] term_cnt_q, term_cnt_d;
  logic [LEN_W-1:0] len_q,      len_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             start_take;
  logic             len_zero;
  logic             last_term;
  logic [LEN_W-1:0] term_cnt_inc;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum;

  // ------------------------------------------------------------------
  // Shared decode
  // ------------------------------------------------------------------
  assign accept       = prod_valid_i && prod_ready_o;
  assign len_zero     = (len_i == '0);
  assign term_cnt_inc = term_cnt_q + 1'b1;
  // len_q is never zero in ACCUM, so count+1 == len marks the final term.
  assign last_term    = (term_cnt_inc == len_q);

  // A start is honoured in IDLE, or in HOLD on the same edge that the
  // consumer takes the result (back-to-back). Elsewhere it is ignored.
  assign start_take = start_i &&
                      ((state_q == IDLE) || ((state_q == HOLD) && acc_ready_i));

  // One ACC_W+1-bit add; the top bit is the carry out of the accumulator.
  assign prod_ext = (ACC_W+1)'(prod_i);
  assign sum      = {1'b0, acc_q} + prod_ext;

  // ------------------------------------------------------------------
  // State register and datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      acc_out_q  <= '0;
      term_cnt_q <= '0;
      len_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      acc_out_q  <= acc_out_d;
      term_cnt_q <= term_cnt_d;
      len_q      <= len_d;
      overflow_q <= overflow_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = len_zero ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && last_term) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (acc_ready_i) begin
          if (start_i) begin
            state_d = len_zero ? HOLD : ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Output decode (state only, no input paths)
  // ------------------------------------------------------------------
  always_comb begin
    prod_ready_o = 1'b0;
    acc_valid_o  = 1'b0;
    busy_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        prod_ready_o = 1'b0;
        acc_valid_o  = 1'b0;
        busy_o       = 1'b0;
      end
      ACCUM: begin
        prod_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
      HOLD: begin
        acc_valid_o  = 1'b1;
        busy_o       = 1'b1;
      end
      default: begin
        prod_ready_o = 1'b0;
        acc_valid_o  = 1'b0;
        busy_o       = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath next-state
  // ------------------------------------------------------------------
  always_comb begin
    acc_d      = acc_q;
    acc_out_d  = acc_out_q;
    term_cnt_d = term_cnt_q;
    len_d      = len_q;
    overflow_d = overflow_q;

    if (start_take) begin
      // New dot product. An empty one (len 0) lands in HOLD with a zero
      // result, so acc_out is cleared here for both cases.
      acc_d      = '0;
      acc_out_d  = '0;
      term_cnt_d = '0;
      len_d      = len_i;
      overflow_d = 1'b0;
    end else if (accept) begin
      acc_d      = sum[ACC_W-1:0];
      overflow_d = overflow_q | sum[ACC_W];
      term_cnt_d = term_cnt_inc;
      if (last_term) begin
        acc_out_d = sum[ACC_W-1:0];
      end
    end
  end

  assign acc_out_o  = acc_out_q;
  assign overflow_o = overflow_q;
  assign term_cnt_o = term_cnt_q;

endmodule : dot_product_accumulator

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator. Instance u_dut uses the default
// widths; u_dut_ovf uses a 65-bit accumulator so the overflow flag can fire.
module tb_dot_product_accumulator;

  localparam int PW  = 64;
  localparam int AW  = 72;
  localparam int AWS = 65;
  localparam int LW  = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;

  logic          start_i;
  logic [LW-1:0] len_i;
  logic          prod_valid_i;
  logic [PW-1:0] prod_i;
  logic          prod_ready_o;
  logic [AW-1:0] acc_out_o;
  logic          acc_valid_o;
  logic          acc_ready_i;
  logic          busy_o;
  logic          overflow_o;
  logic [LW-1:0] term_cnt_o;

  logic           start_b;
  logic [LW-1:0]  len_b;
  logic           prod_valid_b;
  logic [PW-1:0]  prod_b;
  logic           prod_ready_b;
  logic [AWS-1:0] acc_out_b;
  logic           acc_valid_b;
  logic           acc_ready_b;
  logic           busy_b;
  logic           overflow_b;
  logic [LW-1:0]  term_cnt_b;

  int checks     = 0;
  int failures   = 0;
  int proto_errs = 0;

  always #5 clk_i = ~clk_i;

  dot_product_accumulator #(.PROD_W(PW), .ACC_W(AW), .LEN_W(LW)) u_dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .len_i        (len_i),
    .prod_valid_i (prod_valid_i),
    .prod_i       (prod_i),
    .prod_ready_o (prod_ready_o),
    .acc_out_o    (acc_out_o),
    .acc_valid_o  (acc_valid_o),
    .acc_ready_i  (acc_ready_i),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o),
    .term_cnt_o   (term_cnt_o)
  );

  dot_product_accumulator #(.PROD_W(PW), .ACC_W(AWS), .LEN_W(LW)) u_dut_ovf (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_b),
    .len_i        (len_b),
    .prod_valid_i (prod_valid_b),
    .prod_i       (prod_b),
    .prod_ready_o (prod_ready_b),
    .acc_out_o    (acc_out_b),
    .acc_valid_o  (acc_valid_b),
    .acc_ready_i  (acc_ready_b),
    .busy_o       (busy_b),
    .overflow_o   (overflow_b),
    .term_cnt_o   (term_cnt_b)
  );

  // Upstream contract monitor: a product offered while not ready is lost.
  always @(negedge clk_i) begin
    if (rst_n_i && prod_valid_i && !prod_ready_o) begin
      proto_errs++;
      $display("protocol: prod_valid while prod_ready low at %0t (product dropped)", $time);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_start(input logic [LW-1:0] l);
    start_i = 1'b1;
    len_i   = l;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_prod(input logic [PW-1:0] p);
    int n = 0;
    while (!prod_ready_o && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (prod_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL prod_ready_wait: got %b required 1 within 20 cycles", prod_ready_o);
    end
    prod_valid_i = 1'b1;
    prod_i       = p;
    tick();
    prod_valid_i = 1'b0;
  endtask

  task automatic consume();
    acc_ready_i = 1'b1;
    tick();
    acc_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    checks++; if (acc_valid_o !== 1'b0) begin failures++; $display("FAIL reset_acc_valid: got %b required 0", acc_valid_o); end
    checks++; if (prod_ready_o !== 1'b0) begin failures++; $display("FAIL reset_prod_ready: got %b required 0", prod_ready_o); end
    checks++; if (acc_out_o !== '0) begin failures++; $display("FAIL reset_acc_out: got %0h required 0", acc_out_o); end
    checks++; if (term_cnt_o !== '0) begin failures++; $display("FAIL reset_term_cnt: got %0d required 0", term_cnt_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b required 0", overflow_o); end
  endtask

  task automatic test_single_term();
    send_start(8'd1);
    checks++; if (prod_ready_o !== 1'b1 || busy_o !== 1'b1) begin failures++; $display("FAIL single_accum_state: got ready=%b busy=%b required 1 1", prod_ready_o, busy_o); end
    send_prod(64'd3800);
    checks++; if (acc_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid_latency: got %b required 1", acc_valid_o); end
    checks++; if (acc_out_o !== 72'd3800) begin failures++; $display("FAIL single_sum: got %0d required 3800", acc_out_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL single_overflow: got %b required 0", overflow_o); end
    checks++; if (term_cnt_o !== 8'd1) begin failures++; $display("FAIL single_term_cnt: got %0d required 1", term_cnt_o); end
    checks++; if (prod_ready_o !== 1'b0) begin failures++; $display("FAIL single_hold_ready: got %b required 0", prod_ready_o); end
    consume();
    checks++; if (acc_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL single_consume: got valid=%b busy=%b required 0 0", acc_valid_o, busy_o); end
  endtask

  // Leaves its result held in HOLD for the backpressure test.
  task automatic test_three_term();
    send_start(8'd3);
    send_prod(64'd3800);
    send_prod(64'd100);
    checks++; if (acc_valid_o !== 1'b0 || term_cnt_o !== 8'd2) begin failures++; $display("FAIL three_mid: got valid=%b cnt=%0d required 0 2", acc_valid_o, term_cnt_o); end
    send_prod(64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if (acc_valid_o !== 1'b1) begin failures++; $display("FAIL three_valid: got %b required 1", acc_valid_o); end
    checks++; if (acc_out_o !== 72'h01_0000_0000_0000_0F3B) begin failures++; $display("FAIL three_sum: got %0h required 10000000000000f3b", acc_out_o); end
    checks++; if (overflow_o !== 1'b0 || term_cnt_o !== 8'd3) begin failures++; $display("FAIL three_flags: got ovf=%b cnt=%0d required 0 3", overflow_o, term_cnt_o); end
  endtask

  task automatic test_back_to_back();
    int base = proto_errs;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        prod_valid_i = 1'b1;
        prod_i       = 64'd555;
      end
      tick();
      prod_valid_i = 1'b0;
      checks++;
      if (acc_out_o !== 72'h01_0000_0000_0000_0F3B || acc_valid_o !== 1'b1 ||
          prod_ready_o !== 1'b0 || term_cnt_o !== 8'd3) begin
        failures++;
        $display("FAIL hold_stable[%0d]: got out=%0h valid=%b ready=%b cnt=%0d required 10000000000000f3b 1 0 3",
                 i, acc_out_o, acc_valid_o, prod_ready_o, term_cnt_o);
      end
    end
    checks++; if (proto_errs !== base + 1) begin failures++; $display("FAIL proto_flag: got %0d required %0d", proto_errs, base + 1); end
    acc_ready_i = 1'b1;
    start_i     = 1'b1;
    len_i       = 8'd2;
    tick();
    acc_ready_i = 1'b0;
    start_i     = 1'b0;
    checks++; if (acc_valid_o !== 1'b0 || prod_ready_o !== 1'b1 || term_cnt_o !== 8'd0) begin failures++; $display("FAIL b2b_restart: got valid=%b ready=%b cnt=%0d required 0 1 0", acc_valid_o, prod_ready_o, term_cnt_o); end
    send_prod(64'd7);
    send_prod(64'd9);
    checks++; if (acc_valid_o !== 1'b1 || acc_out_o !== 72'd16) begin failures++; $display("FAIL b2b_sum: got valid=%b out=%0d required 1 16", acc_valid_o, acc_out_o); end
    consume();
  endtask

  task automatic test_len_zero_and_ignored_start();
    send_start(8'd0);
    checks++; if (acc_valid_o !== 1'b1 || acc_out_o !== '0 || overflow_o !== 1'b0 || term_cnt_o !== 8'd0) begin failures++; $display("FAIL len0: got valid=%b out=%0h ovf=%b cnt=%0d required 1 0 0 0", acc_valid_o, acc_out_o, overflow_o, term_cnt_o); end
    consume();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL len0_consume: got busy=%b required 0", busy_o); end
    send_start(8'd4);
    send_prod(64'd10);
    start_i = 1'b1;
    len_i   = 8'd1;
    send_prod(64'd20);
    start_i = 1'b0;
    checks++; if (term_cnt_o !== 8'd2 || prod_ready_o !== 1'b1 || acc_valid_o !== 1'b0) begin failures++; $display("FAIL ignored_start: got cnt=%0d ready=%b valid=%b required 2 1 0", term_cnt_o, prod_ready_o, acc_valid_o); end
    send_prod(64'd30);
    send_prod(64'd40);
    checks++; if (acc_valid_o !== 1'b1 || acc_out_o !== 72'd100 || term_cnt_o !== 8'd4) begin failures++; $display("FAIL ignored_start_sum: got valid=%b out=%0d cnt=%0d required 1 100 4", acc_valid_o, acc_out_o, term_cnt_o); end
    consume();
  endtask

  task automatic test_overflow();
    start_b = 1'b1;
    len_b   = 8'd3;
    tick();
    start_b = 1'b0;
    checks++; if (prod_ready_b !== 1'b1) begin failures++; $display("FAIL ovf_ready: got %b required 1", prod_ready_b); end
    for (int i = 0; i < 3; i++) begin
      prod_valid_b = 1'b1;
      prod_b       = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      if (i == 1) begin
        checks++; if (overflow_b !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b required 0", overflow_b); end
      end
    end
    prod_valid_b = 1'b0;
    checks++; if (acc_valid_b !== 1'b1 || overflow_b !== 1'b1) begin failures++; $display("FAIL ovf_flag: got valid=%b ovf=%b required 1 1", acc_valid_b, overflow_b); end
    checks++; if (acc_out_b !== 65'h0_FFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL ovf_wrap: got %0h required fffffffffffffffd", acc_out_b); end
    acc_ready_b = 1'b1;
    tick();
    acc_ready_b = 1'b0;
  endtask

  task automatic test_reset_mid_accum();
    send_start(8'd4);
    send_prod(64'd11);
    send_prod(64'd22);
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    checks++; if (busy_o !== 1'b0 || acc_valid_o !== 1'b0 || term_cnt_o !== 8'd0) begin failures++; $display("FAIL mid_reset: got busy=%b valid=%b cnt=%0d required 0 0 0", busy_o, acc_valid_o, term_cnt_o); end
    checks++; if (prod_ready_o !== 1'b0 || acc_out_o !== '0) begin failures++; $display("FAIL mid_reset_out: got ready=%b out=%0h required 0 0", prod_ready_o, acc_out_o); end
    tick();
    checks++; if (acc_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL mid_reset_idle: got valid=%b busy=%b required 0 0", acc_valid_o, busy_o); end
  endtask

  initial begin
    rst_n_i      = 1'b0;
    start_i      = 1'b0;
    len_i        = '0;
    prod_valid_i = 1'b0;
    prod_i       = '0;
    acc_ready_i  = 1'b0;
    start_b      = 1'b0;
    len_b        = '0;
    prod_valid_b = 1'b0;
    prod_b       = '0;
    acc_ready_b  = 1'b0;

    test_reset();
    test_single_term();
    test_three_term();
    test_back_to_back();
    test_len_zero_and_ignored_start();
    test_overflow();
    test_reset_mid_accum();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dot_product_accumulator

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Downstream consumer of the pipelined 32x32 Wallace multiplier.
- Takes the unsigned 64-bit product stream with a valid/ready handshake.
- Sums a programmed number of consecutive products into a wide accumulator, then presents the dot-product result on a held valid/ready output.
- Turns the multiplier into a MAC/dot-product unit for the datapath.

Parameters:
- PROD_W, 64: product width from the multiplier.
- ACC_W, 72: accumulator/result width; must be >= PROD_W. Default leaves 8 guard bits.
- LEN_W, 8: width of the term-count field. Maximum 2^LEN_W-1 terms per dot product.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- start, input, 1: begin a new dot product. Sampled only when the block can accept it.
- len, input, LEN_W: number of products to sum. Latched on an accepted start.
- prod_valid, input, 1: product on prod is valid.
- prod, input, PROD_W: unsigned product from the multiplier.
- prod_ready, output, 1: block accepts a product this cycle.
- acc_out, output, ACC_W: final sum, stable while acc_valid is high.
- acc_valid, output, 1: result available.
- acc_ready, input, 1: consumer takes the result.
- busy, output, 1: high in ACCUM or HOLD.
- overflow, output, 1: sticky per dot product. Set on carry out of ACC_W.
- term_cnt, output, LEN_W: products accepted so far in the current dot product.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - acc_out, term_cnt, the internal accumulator and the latched len all go to 0.
  - acc_valid, prod_ready, busy and overflow all go to 0.
  - Reset mid-accumulation discards the partial sum. No result is produced.
- States:
  - IDLE: prod_ready=0, acc_valid=0.
    - start=1 with len!=0: go to ACCUM. Clear accumulator, term_cnt and overflow. Latch len.
    - start=1 with len==0: go to HOLD with acc_out=0, overflow=0 (empty dot product).
  - ACCUM: prod_ready=1 combinationally (state-decoded, no input path).
    - Accept when prod_valid&&prod_ready.
    - On accept: acc <= acc + zero-extend(prod), modulo 2^ACC_W. Carry out of bit ACC_W-1 sets overflow (sticky). term_cnt increments.
    - Accept with term_cnt==len-1: acc_out <= final sum, go to HOLD. acc_valid is high the cycle after the last product is accepted (latency 1).
    - start is ignored in ACCUM.
  - HOLD: prod_ready=0, acc_valid=1.
    - acc_out, overflow and term_cnt are held stable until acc_ready=1.
    - acc_ready=1, start=0: go to IDLE.
    - acc_ready=1, start=1: back-to-back. Result is taken, and the same edge applies the IDLE start rules to the new len.
    - acc_ready=0: stay in HOLD. start is ignored.
- Upstream contract: the multiplier pipeline has no stall. The issuing logic must only launch operand pairs whose product arrives while prod_ready=1. prod_valid while prod_ready=0 is dropped and is a protocol error; the bench flags it.
- Overflow with defaults: 255 terms * (2^64-1) < 2^72, so overflow is unreachable. It becomes reachable only with ACC_W overridden smaller.
- Wrap: the sum wraps modulo 2^ACC_W; there is no saturation.
- term_cnt counts up to len only and never wraps.

Decomposition:
- Shared package dp_acc_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - default PROD_W, ACC_W and LEN_W;
  - the shared product-width constant reused by the multiplier.
- Single module, no sub-module. The adder is one ACC_W+1-bit add.

Test Plan:
- Single-term sum: reset, start with len=1, one product 3800 (40*95) -> acc_valid the cycle after accept, acc_out=3800, overflow=0, term_cnt=1.
- Three-term sum: len=3, products 3800, 100, 2^64-1 -> acc_out=2^64+3899, overflow=0.
- Backpressure, then back-to-back start:
  - Hold acc_ready=0 for 5 cycles: acc_out stays stable, prod_ready=0, an extra prod_valid is flagged.
  - Then acc_ready=1 with start=1, len=2, products 7 and 9 -> first result consumed, next acc_out=16.
- len=0 and ignored start:
  - start with len=0 -> HOLD next cycle, acc_valid=1, acc_out=0.
  - start asserted mid-ACCUM -> ignored, sum unaffected.
- Overflow and reset mid-accumulation:
  - ACC_W=65, len=3, products all 2^64-1 -> overflow=1, acc_out=(3*(2^64-1)) mod 2^65.
  - rst_n low after 2 of 4 accepts -> next cycle busy=0, acc_valid=0, term_cnt=0.
